// File: rtl/nco_fsk_ctrl_if.sv
// Byte handshake between the framing/data source and the FSK symbol sequencer.
// The source drives data_in/data_valid and the sequencer answers with data_ready.
interface nco_fsk_ctrl_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/nco_fsk_ctrl.sv
// Binary-FSK symbol sequencer: serialises bytes LSB first onto the NCO frequency
// control word, holding MARK/SPACE for SYM_CYCLES clocks per bit.
module nco_fsk_ctrl #(
    parameter int                     PHASE_WIDTH = 16,
    parameter int                     SYM_CYCLES  = 64,
    parameter logic [PHASE_WIDTH-1:0] FCW_MARK    = 16'd1024,
    parameter logic [PHASE_WIDTH-1:0] FCW_SPACE   = 16'd512,
    parameter logic [PHASE_WIDTH-1:0] FCW_IDLE    = 16'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    nco_fsk_ctrl_if.slave          byte_bus,
    input  logic                   abort,
    output logic [PHASE_WIDTH-1:0] fcw,
    output logic                   nco_rst,
    output logic                   sym_tick,
    output logic                   byte_done,
    output logic                   tx_active
);

    localparam int                CNT_W    = $clog2(SYM_CYCLES);
    localparam logic [CNT_W-1:0]  SYM_LAST = CNT_W'(SYM_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    logic [1:0]       state;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] sym_cnt;
    logic             ready;

    logic sym_last;
    logic byte_last;

    assign sym_last  = (sym_cnt == SYM_LAST);
    assign byte_last = (bit_idx == 3'd7);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            sym_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (byte_bus.data_valid && !abort) begin
                        shreg <= byte_bus.data_in;
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    bit_idx <= '0;
                    sym_cnt <= '0;
                    state   <= abort ? ST_IDLE : ST_SEND;
                end

                ST_SEND: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        bit_idx <= '0;
                        sym_cnt <= '0;
                    end else if (!sym_last) begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end else if (!byte_last) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        sym_cnt <= '0;
                    end else begin
                        // Chaining skips START so the NCO phase stays continuous.
                        bit_idx <= '0;
                        sym_cnt <= '0;
                        if (byte_bus.data_valid) begin
                            shreg <= byte_bus.data_in;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    bit_idx <= '0;
                    sym_cnt <= '0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        fcw       = FCW_IDLE;
        ready     = 1'b0;
        nco_rst   = 1'b0;
        sym_tick  = 1'b0;
        byte_done = 1'b0;
        tx_active = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_START: begin
                nco_rst   = 1'b1;
                tx_active = 1'b1;
            end
            ST_SEND: begin
                fcw       = shreg[0] ? FCW_MARK : FCW_SPACE;
                tx_active = 1'b1;
                sym_tick  = (sym_cnt == '0);
                byte_done = sym_last && byte_last;
                ready     = sym_last && byte_last;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign byte_bus.data_ready = ready;

endmodule
